// File: rtl/wb_stage_if.sv
// Upstream memory-stage to writeback-stage handshake and payload bundle.
// The memory stage uses the master modport; wb_stage uses the slave modport.
`timescale 1ns/1ps
interface wb_stage_if #(
   parameter int XLEN   = 64,
   parameter int RIDX_W = 5
);
   logic              i_wb_memoryed_req;
   logic              o_wb_memoryed_ack;
   logic [XLEN-1:0]   i_wb_pc;
   logic [31:0]       i_wb_inst;
   logic [RIDX_W-1:0] i_wb_rd;
   logic              i_wb_rd_wen;
   logic [XLEN-1:0]   i_wb_rd_wdata;
   logic              i_wb_nocmt;
   logic              i_wb_skipcmt;
   logic [XLEN-1:0]   i_wb_a0;

   modport master (
      output i_wb_memoryed_req, i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen,
             i_wb_rd_wdata, i_wb_nocmt, i_wb_skipcmt, i_wb_a0,
      input  o_wb_memoryed_ack
   );

   modport slave (
      input  i_wb_memoryed_req, i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen,
             i_wb_rd_wdata, i_wb_nocmt, i_wb_skipcmt, i_wb_a0,
      output o_wb_memoryed_ack
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers one retired instruction per handshake, drives the
// register-file/forwarding/commit buses a cycle later, and keeps cycle/instret.
// Optional simulation-trap halt is enabled by defining WB_TRAP_EN.
`timescale 1ns/1ps
module wb_stage #(
   parameter int XLEN   = 64,
   parameter int RIDX_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   wb_stage_if.slave         up,
   output logic              o_rf_wen,
   output logic [RIDX_W-1:0] o_rf_waddr,
   output logic [XLEN-1:0]   o_rf_wdata,
   output logic              o_fwd_valid,
   output logic [RIDX_W-1:0] o_fwd_rd,
   output logic [XLEN-1:0]   o_fwd_data,
   output logic              o_cmt_valid,
   output logic              o_cmt_skip,
   output logic [XLEN-1:0]   o_cmt_pc,
   output logic [31:0]       o_cmt_inst,
   output logic [XLEN-1:0]   o_cycle_cnt,
   output logic [XLEN-1:0]   o_instret_cnt,
   output logic              o_halt,
   output logic [XLEN-1:0]   o_halt_code
);

   logic              valid_q;
   logic [XLEN-1:0]   pc_q;
   logic [31:0]       inst_q;
   logic [RIDX_W-1:0] rd_q;
   logic              rd_wen_q;
   logic [XLEN-1:0]   wdata_q;
   logic              nocmt_q;
   logic              skipcmt_q;
   logic [XLEN-1:0]   cycle_q;
   logic [XLEN-1:0]   instret_q;
   logic              hs;
   logic              rf_wen;
   logic              cmt_valid;

   assign hs = up.i_wb_memoryed_req & up.o_wb_memoryed_ack;

   // Pipeline register plus the free-running cycle and retired-instruction counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         inst_q    <= '0;
         rd_q      <= '0;
         rd_wen_q  <= 1'b0;
         wdata_q   <= '0;
         nocmt_q   <= 1'b0;
         skipcmt_q <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         valid_q <= hs;
         if (hs) begin
            pc_q      <= up.i_wb_pc;
            inst_q    <= up.i_wb_inst;
            rd_q      <= up.i_wb_rd;
            rd_wen_q  <= up.i_wb_rd_wen;
            wdata_q   <= up.i_wb_rd_wdata;
            nocmt_q   <= up.i_wb_nocmt;
            skipcmt_q <= up.i_wb_skipcmt;
         end
         cycle_q <= cycle_q + XLEN'(1);
         if (cmt_valid) begin
            instret_q <= instret_q + XLEN'(1);
         end
      end
   end

   // Gating with rst discards an in-flight instruction the moment reset is raised.
   assign rf_wen    = valid_q & rd_wen_q & (rd_q != '0) & ~rst;
   assign cmt_valid = valid_q & ~nocmt_q & ~rst;

   assign o_rf_wen      = rf_wen;
   assign o_rf_waddr    = rf_wen ? rd_q : '0;
   assign o_rf_wdata    = rf_wen ? wdata_q : '0;
   assign o_fwd_valid   = rf_wen;
   assign o_fwd_rd      = rf_wen ? rd_q : '0;
   assign o_fwd_data    = rf_wen ? wdata_q : '0;
   assign o_cmt_valid   = cmt_valid;
   assign o_cmt_skip    = cmt_valid & skipcmt_q;
   assign o_cmt_pc      = cmt_valid ? pc_q : '0;
   assign o_cmt_inst    = cmt_valid ? inst_q : '0;
   assign o_cycle_cnt   = cycle_q;
   assign o_instret_cnt = instret_q;

`ifdef WB_TRAP_EN
   localparam logic [31:0] TRAP_INST = 32'h0000_006b;

   logic            halted_q;
   logic [XLEN-1:0] halt_code_q;

   // Sticky halt: the first committed trap captures a0 and blocks further intake.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_q    <= 1'b0;
         halt_code_q <= '0;
      end else if (cmt_valid && (inst_q == TRAP_INST) && !halted_q) begin
         halted_q    <= 1'b1;
         halt_code_q <= up.i_wb_a0;
      end
   end

   assign up.o_wb_memoryed_ack = ~halted_q;
   assign o_halt               = halted_q;
   assign o_halt_code          = halt_code_q;
`else
   logic unused_a0;

   assign unused_a0            = ^up.i_wb_a0;
   assign up.o_wb_memoryed_ack = 1'b1;
   assign o_halt               = 1'b0;
   assign o_halt_code          = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected bus activity,
// a negedge monitor pops and compares; a narrow instance exercises counter wrap.
`timescale 1ns/1ps
module tb_wb_stage;
   localparam int XLEN   = 64;
   localparam int RIDX_W = 5;

   typedef struct {
      int unsigned       cyc;
      logic              rf_wen;
      logic [RIDX_W-1:0] waddr;
      logic [XLEN-1:0]   wdata;
      logic              cmt;
      logic              skip;
      logic [XLEN-1:0]   pc;
      logic [31:0]       inst;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_small = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   int unsigned tb_cycle = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   always @(posedge clk) tb_cycle <= tb_cycle + 1;

   wb_stage_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) up_if ();

   logic              o_rf_wen;
   logic [RIDX_W-1:0] o_rf_waddr;
   logic [XLEN-1:0]   o_rf_wdata;
   logic              o_fwd_valid;
   logic [RIDX_W-1:0] o_fwd_rd;
   logic [XLEN-1:0]   o_fwd_data;
   logic              o_cmt_valid;
   logic              o_cmt_skip;
   logic [XLEN-1:0]   o_cmt_pc;
   logic [31:0]       o_cmt_inst;
   logic [XLEN-1:0]   o_cycle_cnt;
   logic [XLEN-1:0]   o_instret_cnt;
   logic              o_halt;
   logic [XLEN-1:0]   o_halt_code;

   wb_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .up            (up_if),
      .o_rf_wen      (o_rf_wen),
      .o_rf_waddr    (o_rf_waddr),
      .o_rf_wdata    (o_rf_wdata),
      .o_fwd_valid   (o_fwd_valid),
      .o_fwd_rd      (o_fwd_rd),
      .o_fwd_data    (o_fwd_data),
      .o_cmt_valid   (o_cmt_valid),
      .o_cmt_skip    (o_cmt_skip),
      .o_cmt_pc      (o_cmt_pc),
      .o_cmt_inst    (o_cmt_inst),
      .o_cycle_cnt   (o_cycle_cnt),
      .o_instret_cnt (o_instret_cnt),
      .o_halt        (o_halt),
      .o_halt_code   (o_halt_code)
   );

   // Narrow instance so both 8-bit counters can be driven through their wrap point.
   wb_stage_if #(.XLEN(8), .RIDX_W(RIDX_W)) small_if ();

   logic              unused_s_rf_wen;
   logic [RIDX_W-1:0] unused_s_rf_waddr;
   logic [7:0]        unused_s_rf_wdata;
   logic              unused_s_fwd_valid;
   logic [RIDX_W-1:0] unused_s_fwd_rd;
   logic [7:0]        unused_s_fwd_data;
   logic              unused_s_cmt_valid;
   logic              unused_s_cmt_skip;
   logic [7:0]        unused_s_cmt_pc;
   logic [31:0]       unused_s_cmt_inst;
   logic [7:0]        s_cycle_cnt;
   logic [7:0]        s_instret_cnt;
   logic              unused_s_halt;
   logic [7:0]        unused_s_halt_code;

   wb_stage #(.XLEN(8), .RIDX_W(RIDX_W)) dut_small (
      .clk           (clk),
      .rst           (rst_small),
      .up            (small_if),
      .o_rf_wen      (unused_s_rf_wen),
      .o_rf_waddr    (unused_s_rf_waddr),
      .o_rf_wdata    (unused_s_rf_wdata),
      .o_fwd_valid   (unused_s_fwd_valid),
      .o_fwd_rd      (unused_s_fwd_rd),
      .o_fwd_data    (unused_s_fwd_data),
      .o_cmt_valid   (unused_s_cmt_valid),
      .o_cmt_skip    (unused_s_cmt_skip),
      .o_cmt_pc      (unused_s_cmt_pc),
      .o_cmt_inst    (unused_s_cmt_inst),
      .o_cycle_cnt   (s_cycle_cnt),
      .o_instret_cnt (s_instret_cnt),
      .o_halt        (unused_s_halt),
      .o_halt_code   (unused_s_halt_code)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, tb_cycle);
      end
   endtask

   // Drives one request for a single cycle; called 1ns after a rising edge.
   task automatic apply_stimulus(
      input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic [RIDX_W-1:0] rd,
      input logic wen, input logic [XLEN-1:0] wdata, input logic nocmt, input logic skip,
      input logic [XLEN-1:0] a0, input logic exp_rf, input logic exp_cmt, input logic exp_skip);
      exp_t e;
      up_if.i_wb_memoryed_req = 1'b1;
      up_if.i_wb_pc           = pc;
      up_if.i_wb_inst         = inst;
      up_if.i_wb_rd           = rd;
      up_if.i_wb_rd_wen       = wen;
      up_if.i_wb_rd_wdata     = wdata;
      up_if.i_wb_nocmt        = nocmt;
      up_if.i_wb_skipcmt      = skip;
      up_if.i_wb_a0           = a0;
      if (exp_rf || exp_cmt) begin
         e.cyc    = tb_cycle + 1;
         e.rf_wen = exp_rf;
         e.waddr  = exp_rf ? rd : '0;
         e.wdata  = exp_rf ? wdata : '0;
         e.cmt    = exp_cmt;
         e.skip   = exp_skip;
         e.pc     = exp_cmt ? pc : '0;
         e.inst   = exp_cmt ? inst : '0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Idle with a junk payload that must be ignored because req is low.
   task automatic idle(input int n);
      up_if.i_wb_memoryed_req = 1'b0;
      up_if.i_wb_pc           = 64'hdead_beef_0000_0004;
      up_if.i_wb_inst         = 32'h0000_006b;
      up_if.i_wb_rd           = 5'd7;
      up_if.i_wb_rd_wen       = 1'b1;
      up_if.i_wb_rd_wdata     = 64'hffff_0000_ffff_0000;
      up_if.i_wb_nocmt        = 1'b0;
      up_if.i_wb_skipcmt      = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: any bus activity must match the oldest expectation on its exact cycle.
   always @(negedge clk) begin
      if (o_rf_wen || o_cmt_valid) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_output", {62'd0, o_rf_wen, o_cmt_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("latency_cycle", 64'(tb_cycle), 64'(mon_e.cyc));
            check_output("rf_wen", 64'(o_rf_wen), 64'(mon_e.rf_wen));
            check_output("rf_waddr", 64'(o_rf_waddr), 64'(mon_e.waddr));
            check_output("rf_wdata", o_rf_wdata, mon_e.wdata);
            check_output("fwd_valid", 64'(o_fwd_valid), 64'(mon_e.rf_wen));
            check_output("fwd_rd", 64'(o_fwd_rd), 64'(mon_e.waddr));
            check_output("fwd_data", o_fwd_data, mon_e.wdata);
            check_output("cmt_valid", 64'(o_cmt_valid), 64'(mon_e.cmt));
            check_output("cmt_skip", 64'(o_cmt_skip), 64'(mon_e.skip));
            check_output("cmt_pc", o_cmt_pc, mon_e.pc);
            check_output("cmt_inst", 64'(o_cmt_inst), 64'(mon_e.inst));
         end
      end else begin
         check_output("idle_zero", 64'(o_fwd_valid | o_cmt_skip | (o_rf_waddr != 0) | (o_rf_wdata != 0)
                      | (o_fwd_rd != 0) | (o_fwd_data != 0) | (o_cmt_pc != 0) | (o_cmt_inst != 0)), 64'd0);
      end
   end

   initial begin
      up_if.i_wb_memoryed_req    = 1'b0;
      up_if.i_wb_pc              = '0;
      up_if.i_wb_inst            = '0;
      up_if.i_wb_rd              = '0;
      up_if.i_wb_rd_wen          = 1'b0;
      up_if.i_wb_rd_wdata        = '0;
      up_if.i_wb_nocmt           = 1'b0;
      up_if.i_wb_skipcmt         = 1'b0;
      up_if.i_wb_a0              = '0;
      small_if.i_wb_memoryed_req = 1'b0;
      small_if.i_wb_pc           = 8'h40;
      small_if.i_wb_inst         = 32'h0000_0013;
      small_if.i_wb_rd           = 5'd1;
      small_if.i_wb_rd_wen       = 1'b1;
      small_if.i_wb_rd_wdata     = 8'h11;
      small_if.i_wb_nocmt        = 1'b0;
      small_if.i_wb_skipcmt      = 1'b0;
      small_if.i_wb_a0           = 8'h00;

      $display("[TB] reset state");
      @(negedge clk);
      check_output("rst_cycle_cnt", o_cycle_cnt, 64'd0);
      check_output("rst_instret_cnt", o_instret_cnt, 64'd0);
      check_output("rst_ack", 64'(up_if.o_wb_memoryed_ack), 64'd1);
      check_output("rst_halt", 64'(o_halt), 64'd0);
      check_output("rst_halt_code", o_halt_code, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] idle 10 cycles");
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_output("idle_cycle_cnt", o_cycle_cnt, 64'd10);
      check_output("idle_instret_cnt", o_instret_cnt, 64'd0);
      check_output("idle_rf_wen", 64'(o_rf_wen), 64'd0);
      check_output("idle_cmt_valid", 64'(o_cmt_valid), 64'd0);
      @(posedge clk);
      #1;

      $display("[TB] single write and commit");
      apply_stimulus(64'h8000_0000, 32'h00a0_0513, 5'd10, 1'b1, 64'ha, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      idle(2);
      @(negedge clk);
      check_output("instret_after_one", o_instret_cnt, 64'd1);
      @(posedge clk);
      #1;

      $display("[TB] write to x0 suppressed");
      apply_stimulus(64'h8000_0004, 32'h0550_0013, 5'd0, 1'b1, 64'h55, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
      idle(2);
      @(negedge clk);
      check_output("instret_after_x0", o_instret_cnt, 64'd2);
      @(posedge clk);
      #1;

      $display("[TB] back-to-back with nocmt and skipcmt");
      apply_stimulus(64'h8000_0008, 32'h0010_0293, 5'd5, 1'b1, 64'h1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0);
      apply_stimulus(64'h8000_000c, 32'h0020_0313, 5'd6, 1'b1, 64'h2, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
      apply_stimulus(64'h8000_0010, 32'h0030_0393, 5'd7, 1'b1, 64'h3, 1'b0, 1'b1, 64'd0, 1'b1, 1'b1, 1'b1);
      idle(2);
      @(negedge clk);
      check_output("instret_after_burst", o_instret_cnt, 64'd4);
      @(posedge clk);
      #1;

      $display("[TB] trap instruction");
      apply_stimulus(64'h8000_0014, 32'h0000_006b, 5'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'h2a, 1'b0, 1'b1, 1'b0);
      idle(1);
      @(negedge clk);
      check_output("instret_after_trap", o_instret_cnt, 64'd5);
`ifdef WB_TRAP_EN
      check_output("halt_set", 64'(o_halt), 64'd1);
      check_output("halt_code", o_halt_code, 64'h2a);
      check_output("ack_halted", 64'(up_if.o_wb_memoryed_ack), 64'd0);
      @(posedge clk);
      #1;
      up_if.i_wb_memoryed_req = 1'b1;
      up_if.i_wb_rd           = 5'd9;
      up_if.i_wb_rd_wen       = 1'b1;
      up_if.i_wb_a0           = 64'h77;
      repeat (3) @(posedge clk);
      #1 up_if.i_wb_memoryed_req = 1'b0;
      @(negedge clk);
      check_output("halt_sticky", 64'(o_halt), 64'd1);
      check_output("halt_code_sticky", o_halt_code, 64'h2a);
      check_output("instret_halted", o_instret_cnt, 64'd5);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_output("halt_cleared", 64'(o_halt), 64'd0);
      check_output("ack_restored", 64'(up_if.o_wb_memoryed_ack), 64'd1);
`else
      check_output("halt_tied_off", 64'(o_halt), 64'd0);
      check_output("halt_code_tied_off", o_halt_code, 64'd0);
      check_output("ack_constant", 64'(up_if.o_wb_memoryed_ack), 64'd1);
`endif
      @(posedge clk);
      #1;

      $display("[TB] reset discards in-flight instruction");
      apply_stimulus(64'h8000_0100, 32'h00b0_0593, 5'd11, 1'b1, 64'hbb, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      up_if.i_wb_memoryed_req = 1'b0;
      @(negedge clk);
      check_output("midrst_cmt_valid", 64'(o_cmt_valid), 64'd0);
      check_output("midrst_rf_wen", 64'(o_rf_wen), 64'd0);
      @(negedge clk);
      check_output("midrst_cycle_cnt", o_cycle_cnt, 64'd0);
      check_output("midrst_instret_cnt", o_instret_cnt, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("postrst_cycle_cnt", o_cycle_cnt, 64'd1);
      check_output("postrst_instret_cnt", o_instret_cnt, 64'd0);
      @(posedge clk);
      #1;

      $display("[TB] counter wrap on 8-bit instance");
      rst_small = 1'b0;
      small_if.i_wb_memoryed_req = 1'b1;
      repeat (255) @(posedge clk);
      @(negedge clk);
      check_output("wrap_cycle_255", 64'(s_cycle_cnt), 64'hff);
      check_output("wrap_instret_254", 64'(s_instret_cnt), 64'hfe);
      @(negedge clk);
      check_output("wrap_cycle_0", 64'(s_cycle_cnt), 64'h00);
      check_output("wrap_instret_255", 64'(s_instret_cnt), 64'hff);
      @(negedge clk);
      check_output("wrap_cycle_1", 64'(s_cycle_cnt), 64'h01);
      check_output("wrap_instret_0", 64'(s_instret_cnt), 64'h00);
      check_output("small_ack", 64'(small_if.o_wb_memoryed_ack), 64'd1);
      small_if.i_wb_memoryed_req = 1'b0;

      @(negedge clk);
      check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
